pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM-subset core (IF/ID/EX/MEM/WB), working alongside the forwarding unit.
- Detects load-use hazards and inserts a one-cycle bubble.
- Freezes the pipeline while a multi-cycle data-memory access is pending.
- Squashes the IF/ID instruction on a taken branch.
- Halts on a memory timeout and keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   localparam int REG_W           = 4;
   localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble, memory freeze with timeout halt,
// branch squash, and saturating stall/flush counters. Control outputs are Mealy.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ID_Rn,
   input  logic [REG_W-1:0] ID_Rm,
   input  logic             ID_uses_Rn,
   input  logic             ID_uses_Rm,
   input  logic [REG_W-1:0] EX_Rd,
   input  logic             EX_RF_enable,
   input  logic             EX_load,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             cnt_clr,
   output logic             pc_ld,
   output logic             ifid_ld,
   output logic             ifid_flush,
   output logic             idex_ld,
   output logic             idex_bubble,
   output logic             exmem_ld,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output state_e           state_dbg
);

   localparam logic [8:0] TIMEOUT_L = 9'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       mem_err_q, mem_err_d;
   logic [8:0] wait_inc;
   logic       load_use;
   logic       miss;
   logic       freeze;
   logic       stall_inc;
   logic       flush_inc;

   assign load_use = EX_load & EX_RF_enable &
                     ((ID_uses_Rn & (ID_Rn == EX_Rd)) | (ID_uses_Rm & (ID_Rm == EX_Rd)));
   assign miss     = mem_req & ~mem_ready;
   // wait_inc counts frozen cycles including the current one
   assign wait_inc = {1'b0, wait_q} + 9'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         wait_q    <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         RUN: begin
            if (miss) begin
               state_d = MEM_WAIT;
               wait_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (!mem_ready) begin
               wait_d = wait_inc[7:0];
               if (wait_inc >= TIMEOUT_L) begin
                  state_d   = HALT;
                  mem_err_d = 1'b1;
               end
            end else begin
               state_d = RUN;
               wait_d  = 8'd0;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      freeze = (state_q == HALT) ||
               ((state_q == MEM_WAIT) && !mem_ready) ||
               ((state_q == RUN) && miss);
      pc_ld        = 1'b1;
      ifid_ld      = 1'b1;
      ifid_flush   = 1'b0;
      idex_ld      = 1'b1;
      idex_bubble  = 1'b0;
      exmem_ld     = 1'b1;
      memwb_bubble = 1'b0;
      if (freeze) begin
         pc_ld        = 1'b0;
         ifid_ld      = 1'b0;
         idex_ld      = 1'b0;
         exmem_ld     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (load_use) begin
         // branch operands are stale during a load-use stall; it re-resolves next cycle
         pc_ld       = 1'b0;
         ifid_ld     = 1'b0;
         idex_bubble = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
      end
      if (reset) begin
         pc_ld        = 1'b0;
         ifid_ld      = 1'b0;
         ifid_flush   = 1'b1;
         idex_ld      = 1'b0;
         idex_bubble  = 1'b1;
         exmem_ld     = 1'b0;
         memwb_bubble = 1'b1;
      end
   end

   assign stall_inc = ~pc_ld & (state_q != HALT) & ~reset;
   assign flush_inc = ifid_flush & ~reset;
   assign mem_err   = mem_err_q;
   assign state_dbg = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (reset),
      .inc_i (stall_inc),
      .clr_i (cnt_clr),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (reset),
      .inc_i (flush_inc),
      .clr_i (cnt_clr),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model of the sequencing rules.
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam int TO = 4;
   localparam int CW = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    ID_Rn, ID_Rm, EX_Rd;
   logic          ID_uses_Rn, ID_uses_Rm, EX_RF_enable, EX_load;
   logic          branch_taken, mem_req, mem_ready, cnt_clr;
   logic          pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble;
   logic          exmem_ld, memwb_bubble, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;
   state_e        state_dbg;

   int checks = 0;
   int errors = 0;

   // reference model: 0 = running, 1 = waiting on memory, 2 = halted
   int       m_mode, m_wait, m_stall, m_flush;
   bit       m_err, m_frozen, m_stalling, m_flushing;
   logic [7:0] exp_v, obs_v;
   state_e   exp_s;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_uses_Rn(ID_uses_Rn), .ID_uses_Rm(ID_uses_Rm),
      .EX_Rd(EX_Rd), .EX_RF_enable(EX_RF_enable), .EX_load(EX_load),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .cnt_clr(cnt_clr),
      .pc_ld(pc_ld), .ifid_ld(ifid_ld), .ifid_flush(ifid_flush), .idex_ld(idex_ld),
      .idex_bubble(idex_bubble), .exmem_ld(exmem_ld), .memwb_bubble(memwb_bubble),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   assign obs_v = {pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld, memwb_bubble, mem_err};

   task automatic model_reset();
      m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
   endtask

   // expected outputs for the current model state and inputs
   task automatic model_eval();
      bit lu;
      bit p, il, fl, dl, bb, el, mb;
      if (reset) model_reset();
      lu = EX_load && EX_RF_enable &&
           ((ID_uses_Rn && ID_Rn == EX_Rd) || (ID_uses_Rm && ID_Rm == EX_Rd));
      m_frozen = (m_mode == 2) || (m_mode == 1 && !mem_ready) ||
                 (m_mode == 0 && mem_req && !mem_ready);
      {p, il, fl, dl, bb, el, mb} = 7'b1101010;
      if (m_frozen) {p, il, dl, el, mb} = 5'b00001;
      else if (lu) {p, il, bb} = 3'b001;
      else if (branch_taken) fl = 1'b1;
      if (reset) {p, il, fl, dl, bb, el, mb} = 7'b0010101;
      m_stalling = !p && (m_mode != 2) && !reset;
      m_flushing = fl && !reset;
      exp_v = {p, il, fl, dl, bb, el, mb, m_err};
      case (m_mode)
         0:       exp_s = RUN;
         1:       exp_s = MEM_WAIT;
         default: exp_s = HALT;
      endcase
   endtask

   task automatic model_step();
      if (reset) begin
         model_reset();
         return;
      end
      if (cnt_clr) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (m_stalling && m_stall < CMAX) m_stall++;
         if (m_flushing && m_flush < CMAX) m_flush++;
      end
      if (m_mode == 0) begin
         if (mem_req && !mem_ready) begin m_mode = 1; m_wait = 1; end
      end else if (m_mode == 1) begin
         if (mem_ready) begin
            m_mode = 0; m_wait = 0;
         end else begin
            m_wait++;
            if (m_wait >= TO) begin m_mode = 2; m_err = 1; end
         end
      end
   endtask

   task automatic settle();
      #2;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      ID_Rn = 4'd0; ID_Rm = 4'd0; ID_uses_Rn = 1'b0; ID_uses_Rm = 1'b0;
      EX_Rd = 4'd0; EX_RF_enable = 1'b0; EX_load = 1'b0;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1; cnt_clr = 1'b0;
   endtask

   task automatic clear_counters();
      idle();
      cnt_clr = 1'b1;
      settle();
      tick();
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      settle();
      checks++;
      if (obs_v !== 8'b0010_1010) begin
         errors++; $display("FAIL reset_outputs got %b exp %b", obs_v, 8'b0010_1010);
      end
      checks++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || state_dbg !== RUN) begin
         errors++; $display("FAIL reset_state got stall=%0d flush=%0d st=%0d exp 0 0 RUN",
                            stall_cnt, flush_cnt, state_dbg);
      end
      tick();
      reset = 1'b0;
      settle();
      checks++;
      if (obs_v !== 8'b1101_0100) begin
         errors++; $display("FAIL after_reset_defaults got %b exp %b", obs_v, 8'b1101_0100);
      end
      tick();
   endtask

   task automatic test_load_use();
      clear_counters();
      EX_load = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd3;
      ID_Rn = 4'd3; ID_uses_Rn = 1'b1; ID_Rm = 4'd5;
      settle();
      checks++;
      if (obs_v !== 8'b0001_1100 || obs_v !== exp_v) begin
         errors++; $display("FAIL load_use_stall got %b exp %b", obs_v, 8'b0001_1100);
      end
      tick();
      EX_load = 1'b0; EX_RF_enable = 1'b0;
      settle();
      checks++;
      if (obs_v !== 8'b1101_0100 || stall_cnt !== 16'd1) begin
         errors++; $display("FAIL load_use_single got %b cnt=%0d exp %b cnt=1",
                            obs_v, stall_cnt, 8'b1101_0100);
      end
      tick();
      EX_load = 1'b1; EX_RF_enable = 1'b1; ID_uses_Rn = 1'b0;
      settle();
      checks++;
      if (pc_ld !== 1'b1 || obs_v !== exp_v) begin
         errors++; $display("FAIL load_use_unused_rn got pc_ld=%b exp 1", pc_ld);
      end
      tick();
      ID_uses_Rm = 1'b1; ID_Rm = 4'd3;
      settle();
      checks++;
      if (idex_bubble !== 1'b1 || obs_v !== exp_v) begin
         errors++; $display("FAIL load_use_rm got %b exp %b", obs_v, exp_v);
      end
      tick();
      EX_Rd = 4'd0; ID_Rm = 4'd0;
      settle();
      checks++;
      if (pc_ld !== 1'b0 || idex_bubble !== 1'b1) begin
         errors++; $display("FAIL load_use_r0 got pc_ld=%b bubble=%b exp 0 1", pc_ld, idex_bubble);
      end
      tick();
      idle();
      settle();
      checks++;
      if (stall_cnt !== 16'd3 || stall_cnt !== 16'(m_stall)) begin
         errors++; $display("FAIL load_use_count got %0d exp 3", stall_cnt);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      clear_counters();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (obs_v !== 8'b0000_0010 || obs_v !== exp_v) begin
            errors++; $display("FAIL mem_freeze[%0d] got %b exp %b", i, obs_v, 8'b0000_0010);
         end
         tick();
      end
      mem_ready = 1'b1;
      settle();
      checks++;
      if (obs_v !== 8'b1101_0100 || state_dbg !== MEM_WAIT) begin
         errors++; $display("FAIL mem_release got %b st=%0d exp %b MEM_WAIT",
                            obs_v, state_dbg, 8'b1101_0100);
      end
      tick();
      idle();
      settle();
      checks++;
      if (state_dbg !== RUN || stall_cnt !== 16'd3) begin
         errors++; $display("FAIL mem_after got st=%0d cnt=%0d exp RUN 3", state_dbg, stall_cnt);
      end
      tick();
   endtask

   task automatic test_branch_vs_load_use();
      clear_counters();
      EX_load = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd7;
      ID_Rn = 4'd7; ID_uses_Rn = 1'b1; branch_taken = 1'b1;
      settle();
      checks++;
      if (ifid_flush !== 1'b0 || idex_bubble !== 1'b1 || pc_ld !== 1'b0) begin
         errors++; $display("FAIL branch_lu_stall got %b exp %b", obs_v, 8'b0001_1100);
      end
      tick();
      EX_load = 1'b0;
      settle();
      checks++;
      if (ifid_flush !== 1'b1 || flush_cnt !== 16'd0) begin
         errors++; $display("FAIL branch_flush got flush=%b cnt=%0d exp 1 0", ifid_flush, flush_cnt);
      end
      tick();
      idle();
      settle();
      checks++;
      if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
         errors++; $display("FAIL branch_counts got flush=%0d stall=%0d exp 1 1", flush_cnt, stall_cnt);
      end
      tick();
   endtask

   task automatic test_all_hazards();
      clear_counters();
      mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
      EX_load = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd2; ID_Rm = 4'd2; ID_uses_Rm = 1'b1;
      settle();
      checks++;
      if (obs_v !== 8'b0000_0010) begin
         errors++; $display("FAIL all_freeze got %b exp %b", obs_v, 8'b0000_0010);
      end
      tick();
      mem_ready = 1'b1;
      settle();
      checks++;
      if (obs_v !== 8'b0001_1100) begin
         errors++; $display("FAIL all_reeval got %b exp %b", obs_v, 8'b0001_1100);
      end
      tick();
      mem_req = 1'b0; EX_load = 1'b0;
      settle();
      checks++;
      if (obs_v !== 8'b1111_0100) begin
         errors++; $display("FAIL all_branch got %b exp %b", obs_v, 8'b1111_0100);
      end
      tick();
      idle();
      settle();
      checks++;
      if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
         errors++; $display("FAIL all_counts got flush=%0d stall=%0d exp 1 2", flush_cnt, stall_cnt);
      end
      tick();
   endtask

   task automatic test_timeout();
      clear_counters();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < TO; i++) begin
         settle();
         checks++;
         if (obs_v !== 8'b0000_0010 || state_dbg === HALT) begin
            errors++; $display("FAIL timeout_freeze[%0d] got %b st=%0d", i, obs_v, state_dbg);
         end
         tick();
      end
      mem_req = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (state_dbg !== HALT || obs_v !== 8'b0000_0011) begin
            errors++; $display("FAIL halt_hold[%0d] got %b st=%0d exp %b HALT",
                               i, obs_v, state_dbg, 8'b0000_0011);
         end
         tick();
      end
      settle();
      checks++;
      if (stall_cnt !== 16'(TO) || stall_cnt !== 16'(m_stall)) begin
         errors++; $display("FAIL halt_count got %0d exp %0d", stall_cnt, TO);
      end
      reset = 1'b1;
      #1;
      model_eval();
      checks++;
      if (mem_err !== 1'b0 || state_dbg !== RUN || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL halt_async_reset got err=%b st=%0d cnt=%0d exp 0 RUN 0",
                            mem_err, state_dbg, stall_cnt);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_saturation();
      clear_counters();
      EX_load = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd9; ID_Rn = 4'd9; ID_uses_Rn = 1'b1;
      for (int i = 0; i < CMAX - 1; i++) begin
         settle();
         tick();
      end
      settle();
      checks++;
      if (stall_cnt !== 16'hFFFE) begin
         errors++; $display("FAIL sat_preload got %h exp fffe", stall_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         settle();
         tick();
      end
      settle();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL sat_hold got %h exp ffff", stall_cnt);
      end
      cnt_clr = 1'b1;
      settle();
      tick();
      cnt_clr = 1'b0;
      settle();
      checks++;
      if (stall_cnt !== 16'd1 - 16'd1) begin
         errors++; $display("FAIL sat_clear_wins got %h exp 0000", stall_cnt);
      end
      tick();
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 2000; n++) begin
         reset        = ($urandom_range(0, 63) == 0);
         ID_Rn        = 4'($urandom_range(0, 3));
         ID_Rm        = 4'($urandom_range(0, 3));
         EX_Rd        = 4'($urandom_range(0, 3));
         ID_uses_Rn   = 1'($urandom_range(0, 1));
         ID_uses_Rm   = 1'($urandom_range(0, 1));
         EX_RF_enable = 1'($urandom_range(0, 1));
         EX_load      = 1'($urandom_range(0, 1));
         branch_taken = 1'($urandom_range(0, 1));
         mem_req      = ($urandom_range(0, 3) == 0);
         mem_ready    = ($urandom_range(0, 3) != 0);
         cnt_clr      = ($urandom_range(0, 31) == 0);
         settle();
         checks++;
         if (obs_v !== exp_v || state_dbg !== exp_s ||
             stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
            errors++;
            $display("FAIL random[%0d] got %b st=%0d s=%0d f=%0d exp %b st=%0d s=%0d f=%0d",
                     n, obs_v, state_dbg, stall_cnt, flush_cnt, exp_v, exp_s, m_stall, m_flush);
         end
         tick();
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_mem_wait();
      test_branch_vs_load_use();
      test_all_hazards();
      test_timeout();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
